// File: rtl/divider_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package divider_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Counter must be able to hold WIDTH.
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/divider_step.sv
// One restoring shift-subtract iteration: shift in a dividend bit, subtract if it fits.
module divider_step
  import divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             din,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             qbit
);

  // One extra bit so the shifted remainder never wraps before the compare.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    shifted = {rem_in, din};
    diff    = shifted - {1'b0, divisor};
    qbit    = (shifted >= {1'b0, divisor});
    rem_out = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned divider, one quotient bit per clock, start/done handshake.
module seq_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_w(WIDTH);

  state_t           state, state_nx;
  logic [WIDTH-1:0] dvd;      // dividend bits shift out the top, quotient bits shift in the bottom
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] rem_nx;
  logic             qbit;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             last;
  logic             dvs_zero;

  assign accept   = start && (state != RUN);
  assign last     = (cnt == CW'(WIDTH - 1));
  assign dvs_zero = (divisor == '0);

  divider_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem),
    .din     (dvd[WIDTH-1]),
    .divisor (dvs),
    .rem_out (rem_nx),
    .qbit    (qbit)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = (state == RUN);
    done     = (state == DONE);
    case (state)
      IDLE, DONE: begin
        if (start)              state_nx = dvs_zero ? DONE : RUN;
        else if (state == DONE) state_nx = IDLE;
      end
      RUN:     if (last) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dvd         <= '0;
      dvs         <= '0;
      rem         <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      dvd         <= dividend;
      dvs         <= divisor;
      rem         <= '0;
      cnt         <= '0;
      div_by_zero <= dvs_zero;
      // Divide by zero resolves at the start edge; results publish with the DONE cycle.
      if (dvs_zero) begin
        quotient  <= '1;
        remainder <= dividend;
      end
    end else if (state == RUN) begin
      dvd <= {dvd[WIDTH-2:0], qbit};
      rem <= rem_nx;
      cnt <= cnt + CW'(1);
      if (last) begin
        quotient  <= {dvd[WIDTH-2:0], qbit};
        remainder <= rem_nx;
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: driver queues expected results, negedge monitor checks them.
module tb_seq_divider;
  localparam int W = 4;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  seq_divider #(.WIDTH(W)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int q;
    int r;
    int z;
    int cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Called just after a negedge; the start is taken at the following posedge.
  task automatic issue(input int a, input int b, input int qe, input int re, input int ze);
    exp_t e;
    e.q   = qe;
    e.r   = re;
    e.z   = ze;
    e.cyc = (b == 0) ? cyc + 1 : cyc + 1 + W;
    sb.push_back(e);
    dividend = a[W-1:0];
    divisor  = b[W-1:0];
    start    = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done) seen = 1;
      else @(negedge clock);
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  task automatic run(input int a, input int b, input int qe, input int re, input int ze);
    issue(a, b, qe, re, ze);
    wait_done();
    @(negedge clock);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_quotient"}, quotient, 0);
    chk({tag, "_remainder"}, remainder, 0);
    chk({tag, "_dbz"}, div_by_zero, 0);
  endtask

  always @(negedge clock) begin
    if (reset_n && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("quotient", quotient, mon_e.q);
        chk("remainder", remainder, mon_e.r);
        chk("div_by_zero", div_by_zero, mon_e.z);
        chk("latency_cycle", cyc, mon_e.cyc);
        chk("busy_in_done", busy, 0);
      end
    end
  end

  initial begin
    int d, v;
    repeat (2) @(negedge clock);
    chk_zero("reset");
    reset_n = 1'b1;
    @(negedge clock);

    run(8, 2, 4, 0, 0);
    run(7, 3, 2, 1, 0);
    run(15, 1, 15, 0, 0);
    run(3, 9, 0, 3, 0);
    run(0, 5, 0, 0, 0);
    run(15, 15, 1, 0, 0);
    run(5, 0, 15, 5, 1);
    run(6, 3, 2, 0, 0);

    // Start held high during RUN with changed operands must be ignored.
    issue(7, 3, 2, 1, 0);
    chk("busy_in_run", busy, 1);
    start    = 1'b1;
    dividend = 4'd15;
    divisor  = 4'd1;
    repeat (2) @(negedge clock);
    start = 1'b0;
    wait_done();
    @(negedge clock);

    // Back-to-back starts issued in the DONE cycle.
    issue(9, 4, 2, 1, 0);
    wait_done();
    issue(14, 5, 2, 4, 0);
    wait_done();
    issue(5, 0, 15, 5, 1);
    wait_done();
    issue(6, 3, 2, 0, 0);
    wait_done();
    @(negedge clock);

    d = 8;
    v = 2;
    for (int k = 0; k < 16; k++) begin
      d = (d - 1) & 15;
      v = (v + 1) & 15;
      if (v == 0) run(d, v, 15, d, 1);
      else        run(d, v, d / v, d % v, 0);
    end

    // Reset in the middle of a divide aborts with no done pulse.
    issue(7, 2, 3, 1, 0);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk_zero("midrun_reset");
    sb.delete();
    @(negedge clock);
    reset_n = 1'b1;
    repeat (W + 3) @(negedge clock);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);

    run(7, 2, 3, 1, 0);
    repeat (2) @(negedge clock);
    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
